// File: rtl/clock_mode_ctrl_pkg.sv
// Shared types and constants for the alarm-clock sequencer (clock_mode_ctrl).
// The snooze feature is built only when SNOOZE_EN is defined.
package clk_ctrl_pkg;

    localparam int unsigned NS         = 60;
    localparam int unsigned NH         = 24;
    localparam int unsigned ND         = 7;
    localparam int unsigned RING_SECS  = 60;
    localparam int unsigned SNOOZE_MIN = 5;

    localparam int unsigned VAL_W     = 7;
    localparam int unsigned SAT       = 5;
    localparam int unsigned SUN       = 6;
    localparam int unsigned RING_W    = $clog2(RING_SECS);
    localparam int unsigned SNZ_TICKS = SNOOZE_MIN * NS;
    localparam int unsigned SNZ_W     = $clog2(SNZ_TICKS);

    typedef enum logic [1:0] {RUN, TSET, ASET} mode_t;
    typedef enum logic [1:0] {A_IDLE, A_RING, A_SNOOZE} alarm_st_t;

    // Hours/minutes pair, used for both the time and the alarm setting
    typedef struct packed {
        logic [VAL_W-1:0] hrs;
        logic [VAL_W-1:0] mins;
    } hm_t;

    function automatic logic is_weekend(input logic [VAL_W-1:0] day);
        return (day == VAL_W'(SAT)) || (day == VAL_W'(SUN));
    endfunction

endpackage

// File: rtl/clock_mode_ctrl_if.sv
// Button, counter-status and enable bundle between the clock datapath and clock_mode_ctrl.
// Snooze is always present on the bundle; it only has effect when SNOOZE_EN is defined.
interface clock_mode_ctrl_if;

    logic Pulse;
    logic Timeset;
    logic Alarmset;
    logic Minadv;
    logic Hrsadv;
    logic Dysadv;
    logic Alarmon;
    logic Snooze;
    logic sec_max;
    logic min_max;
    logic hrs_max;
    logic [clk_ctrl_pkg::VAL_W-1:0] TMin;
    logic [clk_ctrl_pkg::VAL_W-1:0] THrs;
    logic [clk_ctrl_pkg::VAL_W-1:0] TDys;
    logic [clk_ctrl_pkg::VAL_W-1:0] AMin;
    logic [clk_ctrl_pkg::VAL_W-1:0] AHrs;

    logic sec_en;
    logic min_en;
    logic hrs_en;
    logic dys_en;
    logic amin_en;
    logic ahrs_en;
    logic disp_alarm;
    logic Buzz;

    modport master (
        output Pulse, Timeset, Alarmset, Minadv, Hrsadv, Dysadv, Alarmon, Snooze,
        output sec_max, min_max, hrs_max, TMin, THrs, TDys, AMin, AHrs,
        input  sec_en, min_en, hrs_en, dys_en, amin_en, ahrs_en, disp_alarm, Buzz
    );

    modport slave (
        input  Pulse, Timeset, Alarmset, Minadv, Hrsadv, Dysadv, Alarmon, Snooze,
        input  sec_max, min_max, hrs_max, TMin, THrs, TDys, AMin, AHrs,
        output sec_en, min_en, hrs_en, dys_en, amin_en, ahrs_en, disp_alarm, Buzz
    );

endinterface

// File: rtl/clock_mode_ctrl_alarm_seq.sv
// Alarm ring sequencer: match edge detect, ring/snooze FSM, tick counters and registered Buzz.
// Snooze state and its counter exist only when SNOOZE_EN is defined.
module alarm_seq
    import clk_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_pulse,
    input  logic             i_alarmon,
    input  logic             i_tset,
`ifdef SNOOZE_EN
    input  logic             i_snooze,
`endif
    input  hm_t              i_time,
    input  hm_t              i_alarm,
    input  logic [VAL_W-1:0] i_tdys,
    output logic             o_buzz
);

    alarm_st_t         r_state;
    logic              r_match_q;
    logic              r_buzz;
    logic [RING_W-1:0] r_ring_ct;
`ifdef SNOOZE_EN
    logic [SNZ_W-1:0]  r_snz_ct;
`endif

    logic w_match;
    logic w_trig;
    logic w_start;

    assign w_match = (i_time == i_alarm);
    assign w_trig  = w_match & ~r_match_q;
    assign w_start = w_trig & i_alarmon & ~is_weekend(i_tdys) & ~i_tset;

    // Buzz trails the state by one clock so it is a clean registered output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= A_IDLE;
            r_match_q <= 1'b0;
            r_buzz    <= 1'b0;
            r_ring_ct <= '0;
`ifdef SNOOZE_EN
            r_snz_ct  <= '0;
`endif
        end else begin
            r_match_q <= w_match;
            r_buzz    <= (r_state == A_RING);
            case (r_state)
                A_IDLE: begin
                    if (w_start) begin
                        r_state   <= A_RING;
                        r_ring_ct <= '0;
                    end
                end
                A_RING: begin
                    if (!i_alarmon) begin
                        r_state <= A_IDLE;
                    end
`ifdef SNOOZE_EN
                    else if (i_snooze) begin
                        r_state  <= A_SNOOZE;
                        r_snz_ct <= '0;
                    end
`endif
                    else if (i_pulse) begin
                        if (r_ring_ct == RING_W'(RING_SECS - 1)) begin
                            r_state <= A_IDLE;
                        end else begin
                            r_ring_ct <= r_ring_ct + RING_W'(1);
                        end
                    end
                end
`ifdef SNOOZE_EN
                A_SNOOZE: begin
                    if (!i_alarmon) begin
                        r_state <= A_IDLE;
                    end else if (i_pulse) begin
                        if (r_snz_ct == SNZ_W'(SNZ_TICKS - 1)) begin
                            r_state   <= A_RING;
                            r_ring_ct <= '0;
                        end else begin
                            r_snz_ct <= r_snz_ct + SNZ_W'(1);
                        end
                    end
                end
`endif
                default: r_state <= A_IDLE;
            endcase
        end
    end

    assign o_buzz = r_buzz;

endmodule

// File: rtl/clock_mode_ctrl.sv
// Alarm-clock sequencer top: button mode register, counter-enable decode and alarm sequencer.
// Define SNOOZE_EN to build the snooze feature.
module clock_mode_ctrl
    import clk_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    clock_mode_ctrl_if.slave   bus
);

    mode_t r_mode;
    mode_t w_mode_nxt;

    logic w_sec_en;
    logic w_min_en;
    logic w_hrs_en;
    logic w_dys_en;
    logic w_amin_en;
    logic w_ahrs_en;
    logic w_buzz;
    hm_t  w_time;
    hm_t  w_alarm;

    // Timeset has priority over Alarmset
    always_comb begin
        w_mode_nxt = RUN;
        if (bus.Timeset) begin
            w_mode_nxt = TSET;
        end else if (bus.Alarmset) begin
            w_mode_nxt = ASET;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mode <= RUN;
        end else begin
            r_mode <= w_mode_nxt;
        end
    end

    // Pulse-gated enables; fields ripple-carry except while setting the time
    always_comb begin
        w_sec_en  = 1'b0;
        w_min_en  = 1'b0;
        w_hrs_en  = 1'b0;
        w_dys_en  = 1'b0;
        w_amin_en = 1'b0;
        w_ahrs_en = 1'b0;
        case (r_mode)
            TSET: begin
                w_min_en = bus.Pulse & bus.Minadv;
                w_hrs_en = bus.Pulse & bus.Hrsadv;
                w_dys_en = bus.Pulse & bus.Dysadv;
            end
            default: begin
                w_sec_en = bus.Pulse;
                w_min_en = w_sec_en & bus.sec_max;
                w_hrs_en = w_min_en & bus.min_max;
                w_dys_en = w_hrs_en & bus.hrs_max;
            end
        endcase
        if (r_mode == ASET) begin
            w_amin_en = bus.Pulse & bus.Minadv;
            w_ahrs_en = bus.Pulse & bus.Hrsadv;
        end
    end

    assign w_time.mins  = bus.TMin;
    assign w_time.hrs   = bus.THrs;
    assign w_alarm.mins = bus.AMin;
    assign w_alarm.hrs  = bus.AHrs;

    alarm_seq u_alarm_seq (
        .clk       (clk),
        .rst_n     (rst),
        .i_pulse   (bus.Pulse),
        .i_alarmon (bus.Alarmon),
        .i_tset    (r_mode == TSET),
`ifdef SNOOZE_EN
        .i_snooze  (bus.Snooze),
`endif
        .i_time    (w_time),
        .i_alarm   (w_alarm),
        .i_tdys    (bus.TDys),
        .o_buzz    (w_buzz)
    );

    assign bus.sec_en     = w_sec_en;
    assign bus.min_en     = w_min_en;
    assign bus.hrs_en     = w_hrs_en;
    assign bus.dys_en     = w_dys_en;
    assign bus.amin_en    = w_amin_en;
    assign bus.ahrs_en    = w_ahrs_en;
    assign bus.disp_alarm = (r_mode == ASET);
    assign bus.Buzz       = w_buzz;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Self-checking bench for clock_mode_ctrl: enable-decode vector table plus alarm ring sequences.
// The snooze sequence runs only when SNOOZE_EN is defined.
module tb_clock_mode_ctrl;
    import clk_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;

    clock_mode_ctrl_if bus ();

    clock_mode_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Output vector order: sec, min, hrs, dys, amin, ahrs, disp_alarm, Buzz
    logic [7:0] w_outs;
    assign w_outs = {bus.sec_en, bus.min_en, bus.hrs_en, bus.dys_en,
                     bus.amin_en, bus.ahrs_en, bus.disp_alarm, bus.Buzz};

    localparam logic [7:0] M_ALL  = 8'hFF;
    localparam logic [7:0] M_EN   = 8'hF0;
    localparam logic [7:0] M_DISP = 8'h02;
    localparam logic [7:0] M_BUZZ = 8'h01;

    typedef struct {
        string      name;
        logic [7:0] exp;
        logic [7:0] mask;
    } sb_t;

    typedef struct {
        string      name;
        logic       ts, as, p, madv, hadv, dadv, smax, mmax, hmax;
        logic [7:0] exp;
    } vec_t;

    sb_t  sb_q[$];
    vec_t vt[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(input string nm, input logic [8:0] in_bits, input logic [7:0] e);
        vec_t v;
        v.name = nm;
        {v.ts, v.as, v.p, v.madv, v.hadv, v.dadv, v.smax, v.mmax, v.hmax} = in_bits;
        v.exp  = e;
        return v;
    endfunction

    task automatic push_exp(input string nm, input logic [7:0] e, input logic [7:0] m);
        sb_t s;
        s.name = nm;
        s.exp  = e;
        s.mask = m;
        sb_q.push_back(s);
    endtask

    task automatic pop_cmp();
        sb_t s;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_underflow: no expectation queued");
            return;
        end
        s = sb_q.pop_front();
        if ((w_outs & s.mask) !== (s.exp & s.mask)) begin
            errors++;
            $display("FAIL %s: got %b expected %b (mask %b)",
                     s.name, w_outs & s.mask, s.exp & s.mask, s.mask);
        end
    endtask

    task automatic expect_now(input string nm, input logic [7:0] e, input logic [7:0] m);
        push_exp(nm, e, m);
        #1;
        pop_cmp();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic pulse_tick();
        bus.Pulse = 1'b1;
        step();
        bus.Pulse = 1'b0;
        step();
    endtask

    task automatic clear_qual();
        bus.Pulse   = 1'b0;
        bus.Minadv  = 1'b0;
        bus.Hrsadv  = 1'b0;
        bus.Dysadv  = 1'b0;
        bus.sec_max = 1'b0;
        bus.min_max = 1'b0;
        bus.hrs_max = 1'b0;
    endtask

    initial begin
        rst          = 1'b0;
        bus.Timeset  = 1'b0;
        bus.Alarmset = 1'b0;
        bus.Alarmon  = 1'b0;
        bus.Snooze   = 1'b0;
        clear_qual();
        bus.TMin = 7'd0;
        bus.THrs = 7'd0;
        bus.TDys = 7'd2;
        bus.AMin = 7'd30;
        bus.AHrs = 7'd7;

        //                       ts as p  ma ha da sm mm hm
        vt.push_back(mk("run_carry_hrs",   9'b0_0_1_0_0_0_1_1_0, 8'b1110_0000));
        vt.push_back(mk("run_carry_day",   9'b0_0_1_0_0_0_1_1_1, 8'b1111_0000));
        vt.push_back(mk("run_no_secmax",   9'b0_0_1_0_0_0_0_1_1, 8'b1000_0000));
        vt.push_back(mk("run_no_pulse",    9'b0_0_0_0_0_0_1_1_1, 8'b0000_0000));
        vt.push_back(mk("run_adv_ignored", 9'b0_0_1_1_1_1_0_0_0, 8'b1000_0000));
        vt.push_back(mk("tset_minadv",     9'b1_0_1_1_0_0_1_1_0, 8'b0100_0000));
        vt.push_back(mk("tset_hrs_dys",    9'b1_0_1_0_1_1_1_1_0, 8'b0011_0000));
        vt.push_back(mk("tset_no_carry",   9'b1_0_1_0_0_0_1_1_1, 8'b0000_0000));
        vt.push_back(mk("both_btn_tset",   9'b1_1_1_1_0_0_0_0_0, 8'b0100_0000));
        vt.push_back(mk("aset_adv_run",    9'b0_1_1_1_1_0_1_0_0, 8'b1100_1110));
        vt.push_back(mk("aset_no_pulse",   9'b0_1_0_1_1_0_1_1_1, 8'b0000_0010));
        vt.push_back(mk("aset_carry",      9'b0_1_1_0_0_0_1_1_1, 8'b1111_0010));

        #2;
        expect_now("reset_state", 8'h00, M_ALL);
        steps(2);
        rst = 1'b1;
        step();

        // Enable decode table: buttons latch on one edge, then qualifiers are applied
        foreach (vt[i]) begin
            clear_qual();
            bus.Timeset  = vt[i].ts;
            bus.Alarmset = vt[i].as;
            step();
            bus.Pulse   = vt[i].p;
            bus.Minadv  = vt[i].madv;
            bus.Hrsadv  = vt[i].hadv;
            bus.Dysadv  = vt[i].dadv;
            bus.sec_max = vt[i].smax;
            bus.min_max = vt[i].mmax;
            bus.hrs_max = vt[i].hmax;
            expect_now(vt[i].name, vt[i].exp, M_ALL);
        end

        // RUN carry enables are one clock wide
        clear_qual();
        bus.Timeset  = 1'b0;
        bus.Alarmset = 1'b0;
        step();
        bus.sec_max = 1'b1;
        bus.min_max = 1'b1;
        bus.Pulse   = 1'b1;
        expect_now("run_pulse_hi", 8'b1110_0000, M_EN);
        step();
        bus.Pulse = 1'b0;
        expect_now("run_pulse_lo", 8'h00, M_EN);

        // Three Minadv pulses in TSET, no seconds or hours activity
        bus.Timeset = 1'b1;
        bus.Minadv  = 1'b1;
        step();
        for (int n = 0; n < 3; n++) begin
            bus.Pulse = 1'b1;
            expect_now("tset_min_pulse", 8'b0100_0000, M_EN);
            step();
            bus.Pulse = 1'b0;
            expect_now("tset_gap", 8'h00, M_EN);
            step();
        end
        clear_qual();
        bus.Timeset = 1'b0;
        step();

        // disp_alarm follows Alarmset one clock later
        bus.Alarmset = 1'b1;
        expect_now("disp_before_edge", 8'h00, M_DISP);
        step();
        expect_now("disp_after_edge", 8'h02, M_DISP);
        bus.Alarmset = 1'b0;
        step();
        expect_now("disp_release", 8'h00, M_DISP);

        // Weekday alarm: TMin 29 -> 30
        bus.THrs    = 7'd7;
        bus.TMin    = 7'd29;
        bus.TDys    = 7'd2;
        bus.Alarmon = 1'b1;
        steps(2);
        expect_now("no_match_quiet", 8'h00, M_BUZZ);
        bus.TMin = 7'd30;
        step();
        expect_now("buzz_entry_latency", 8'h00, M_BUZZ);
        step();
        expect_now("buzz_on", 8'h01, M_BUZZ);
        for (int n = 0; n < 59; n++) pulse_tick();
        expect_now("ring_59_pulses", 8'h01, M_BUZZ);
        pulse_tick();
        expect_now("auto_stop_60", 8'h00, M_BUZZ);
        steps(3);
        expect_now("no_retrigger_same_min", 8'h00, M_BUZZ);

        // New rising edge rings again; Alarmon low stops it
        bus.TMin = 7'd31;
        step();
        bus.TMin = 7'd30;
        steps(2);
        expect_now("retrigger", 8'h01, M_BUZZ);
        bus.Alarmon = 1'b0;
        steps(2);
        expect_now("alarmon_off", 8'h00, M_BUZZ);

        // Match while in TSET does not start the ring
        bus.Alarmon = 1'b1;
        bus.TMin    = 7'd31;
        step();
        bus.Timeset = 1'b1;
        step();
        bus.TMin = 7'd30;
        steps(3);
        expect_now("tset_blocks_ring", 8'h00, M_BUZZ);
        bus.Timeset = 1'b0;
        bus.TMin    = 7'd31;
        steps(2);

        // Weekend days suppress the alarm
        for (int d = 5; d <= 6; d++) begin
            bus.TDys = 7'(d);
            bus.TMin = 7'd31;
            step();
            bus.TMin = 7'd30;
            steps(3);
            expect_now($sformatf("weekend_day%0d", d), 8'h00, M_BUZZ);
        end

        // Reset mid-ring clears Buzz at once; only a fresh match edge rings again
        bus.TDys = 7'd2;
        bus.TMin = 7'd31;
        step();
        bus.TMin = 7'd30;
        steps(2);
        expect_now("ring_before_rst", 8'h01, M_BUZZ);
        rst = 1'b0;
        expect_now("rst_mid_ring", 8'h00, M_ALL);
        bus.TMin = 7'd31;
        step();
        rst = 1'b1;
        steps(3);
        expect_now("no_ring_after_rst", 8'h00, M_BUZZ);
        bus.TMin = 7'd30;
        steps(2);
        expect_now("ring_after_new_edge", 8'h01, M_BUZZ);
        bus.Alarmon = 1'b0;
        steps(2);
        expect_now("ring_stopped", 8'h00, M_BUZZ);

`ifdef SNOOZE_EN
        // Snooze silences for SNOOZE_MIN*NS pulses then rings again
        bus.Alarmon = 1'b1;
        bus.TMin    = 7'd31;
        step();
        bus.TMin = 7'd30;
        steps(2);
        expect_now("snz_ring", 8'h01, M_BUZZ);
        bus.Snooze = 1'b1;
        step();
        bus.Snooze = 1'b0;
        step();
        expect_now("snz_quiet", 8'h00, M_BUZZ);
        for (int n = 0; n < 299; n++) pulse_tick();
        expect_now("snz_299", 8'h00, M_BUZZ);
        pulse_tick();
        expect_now("snz_resume", 8'h01, M_BUZZ);
        bus.Alarmon = 1'b0;
        steps(2);
        expect_now("snz_off", 8'h00, M_BUZZ);
`endif

        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: %0d entries remain, expected 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
